// File: rtl/mult_issue_ctrl.sv
// Operand scheduler for the serial shift-add multiplier: queues signed operand
// pairs, issues one at a time when the multiplier is idle, and holds each product for a valid/ready sink.
module mult_issue_ctrl #(
    parameter int M       = 5,
    parameter int N       = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [M-1:0]             s_a,
    input  logic [N-1:0]             s_b,
    output logic                     mult_enable,
    output logic [M-1:0]             mult_in_a,
    output logic [N-1:0]             mult_in_b,
    input  logic [M+N-1:0]           mult_out,
    input  logic                     mult_out_valid,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [M+N-1:0]           m_data,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    // state  | meaning
    // IDLE   | waiting for a queued pair and an empty result register
    // ISSUE  | one-cycle start pulse, FIFO head popped
    // WAIT   | waiting for the product strobe or the timeout
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    logic [M-1:0]   mem_a [DEPTH];
    logic [N-1:0]   mem_b [DEPTH];

    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           s_ready_q;
    logic [1:0]     state_q, state_d;
    logic [TW-1:0]  wcnt_q, wcnt_d;
    logic [M-1:0]   ina_q, ina_d;
    logic [N-1:0]   inb_q, inb_d;
    logic           mval_q, mval_d;
    logic [M+N-1:0] mdata_q, mdata_d;
    logic           terr_q, terr_d;

    logic push, pop;

    // s_ready is a registered copy of (count < DEPTH), so a pop never frees a slot the same cycle
    assign push = s_valid && s_ready_q;
    assign pop  = (state_q == S_ISSUE);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q] <= s_a;
            mem_b[wr_ptr_q] <= s_b;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        ina_d   = ina_q;
        inb_d   = inb_q;
        mval_d  = mval_q;
        mdata_d = mdata_q;
        terr_d  = terr_q;

        if (mval_q && m_ready) begin
            mval_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !mval_q) begin
                    state_d = S_ISSUE;
                    ina_d   = mem_a[rd_ptr_q];
                    inb_d   = mem_b[rd_ptr_q];
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wcnt_d  = '0;
            end
            S_WAIT: begin
                // a strobe on the last wait cycle still wins over the timeout
                if (mult_out_valid) begin
                    mdata_d = mult_out;
                    mval_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b1;
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            ina_q     <= '0;
            inb_q     <= '0;
            mval_q    <= 1'b0;
            mdata_q   <= '0;
            terr_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q   <= count_d;
            s_ready_q <= (count_d < CW'(DEPTH));
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            ina_q     <= ina_d;
            inb_q     <= inb_d;
            mval_q    <= mval_d;
            mdata_q   <= mdata_d;
            terr_q    <= terr_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign mult_enable = (state_q == S_ISSUE);
    assign mult_in_a   = ina_q;
    assign mult_in_b   = inb_q;
    assign m_valid     = mval_q;
    assign m_data      = mdata_q;
    assign timeout_err = terr_q;
    assign fifo_count  = count_q;
    assign busy        = (state_q != S_IDLE) || (count_q != '0) || mval_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a behavioural multiplier model and
// a result scoreboard fed at operand acceptance.
module tb_mult_issue_ctrl;

    localparam int M       = 5;
    localparam int N       = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;
    localparam int W       = M + N;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  s_valid;
    logic                  s_ready;
    logic [M-1:0]          s_a;
    logic [N-1:0]          s_b;
    logic                  mult_enable;
    logic [M-1:0]          mult_in_a;
    logic [N-1:0]          mult_in_b;
    logic [W-1:0]          mult_out = '0;
    logic                  mult_out_valid = 1'b0;
    logic                  m_valid;
    logic                  m_ready;
    logic [W-1:0]          m_data;
    logic                  busy;
    logic                  timeout_err;
    logic [$clog2(DEPTH):0] fifo_count;

    mult_issue_ctrl #(.M(M), .N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .mult_enable(mult_enable), .mult_in_a(mult_in_a), .mult_in_b(mult_in_b),
        .mult_out(mult_out), .mult_out_valid(mult_out_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .timeout_err(timeout_err), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb_q [$];
    int model_delay = 5;
    int rem = 0;
    int en_count = 0;
    int max_count = 0;
    logic prev_en = 1'b0;
    logic [M-1:0] la = '0;
    logic [N-1:0] lb = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] prod(input logic [M-1:0] a, input logic [N-1:0] b);
        logic signed [W-1:0] ea, eb, p;
        ea = {{N{a[M-1]}}, a};
        eb = {{M{b[N-1]}}, b};
        p  = ea * eb;
        return p;
    endfunction

    // multiplier model: strobe model_delay cycles after the enable pulse; negative = never
    always @(posedge clk) begin
        #2;
        mult_out_valid = 1'b0;
        if (!rst_n) begin
            rem = 0;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                mult_out_valid = 1'b1;
                mult_out       = prod(la, lb);
            end
        end
        if (rst_n && mult_enable) begin
            la  = mult_in_a;
            lb  = mult_in_b;
            rem = (model_delay < 0) ? 0 : model_delay;
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        #1;
        if (rst_n) begin
            if (mult_enable) begin
                en_count++;
                chk("en_width", {31'd0, prev_en}, 32'd0);
            end
            prev_en = mult_enable;
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_data", {23'd0, m_data}, {23'd0, e});
                end
            end
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic push(input logic [M-1:0] a, input logic [N-1:0] b, input bit exp_res);
        bit acc;
        int n;
        n = 0;
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        do begin
            acc = s_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 50);
        chk("push_accept", {31'd0, acc}, 32'd1);
        if (acc && exp_res) sb_q.push_back(prod(a, b));
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int n;
        logic [M-1:0] ta;
        logic [N-1:0] tb;

        rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 1);
        chk("rst_m_valid", {31'd0, m_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_count", {29'd0, fifo_count}, 0);
        chk("rst_enable", {31'd0, mult_enable}, 0);
        chk("rst_terr", {31'd0, timeout_err}, 0);
        chk("rst_mdata", {23'd0, m_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single op: -7 * 3
        push(5'b11001, 4'b0011, 1'b1);
        s_valid = 1'b0;
        chk("t1_en_e0", {31'd0, mult_enable}, 0);
        chk("t1_cnt_e0", {29'd0, fifo_count}, 1);
        @(negedge clk);
        chk("t1_en_e1", {31'd0, mult_enable}, 1);
        chk("t1_in_a", {27'd0, mult_in_a}, 32'h19);
        chk("t1_in_b", {28'd0, mult_in_b}, 32'h3);
        @(negedge clk);
        chk("t1_en_e2", {31'd0, mult_enable}, 0);
        chk("t1_cnt_e2", {29'd0, fifo_count}, 0);
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_hold_a", {27'd0, mult_in_a}, 32'h19);
        n = 0;
        while (!mult_out_valid && n < 50) begin @(negedge clk); n++; end
        chk("t1_strobe", {31'd0, mult_out_valid}, 1);
        chk("t1_mv_pre", {31'd0, m_valid}, 0);
        @(negedge clk);
        chk("t1_mv_post", {31'd0, m_valid}, 1);
        chk("t1_mdata", {23'd0, m_data}, 32'h1EB);
        repeat (3) @(negedge clk);
        chk("t1_mv_hold", {31'd0, m_valid}, 1);
        m_ready = 1'b1;
        @(negedge clk);
        chk("t1_mv_clr", {31'd0, m_valid}, 0);
        chk("t1_busy_clr", {31'd0, busy}, 0);
        m_ready = 1'b0;

        // backpressure: (5,-8) then (3,3)
        e0 = en_count;
        push(5'd5, 4'b1000, 1'b1);
        push(5'd3, 4'd3, 1'b1);
        s_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("t2_mv", {31'd0, m_valid}, 1);
        chk("t2_mdata", {23'd0, m_data}, 32'h1D8);
        chk("t2_one_issue", en_count - e0, 1);
        chk("t2_cnt", {29'd0, fifo_count}, 1);
        m_ready = 1'b1;
        drain(60);
        chk("t2_two_issue", en_count - e0, 2);
        m_ready = 1'b0;

        // FIFO full with result held
        max_count = 0;
        for (int i = 0; i < 5; i++) begin
            ta = M'(3 * i + 2);
            tb = N'(i - 3);
            push(ta, tb, 1'b1);
        end
        s_valid = 1'b1; s_a = 5'b10101; s_b = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_full_rdy", {31'd0, s_ready}, 0);
            chk("t3_full_cnt", {29'd0, fifo_count}, 4);
        end
        m_ready = 1'b1;
        push(5'b10101, 4'b0110, 1'b1);
        s_valid = 1'b0;
        drain(300);
        chk("t3_max_cnt", max_count, 4);
        m_ready = 1'b0;

        // timeout, then late strobe ignored, then a normal op
        model_delay = 40;
        push(5'd7, 4'd2, 1'b0);
        s_valid = 1'b0;
        n = 0;
        while (!mult_enable && n < 20) begin @(negedge clk); n++; end
        chk("t4_en_seen", {31'd0, mult_enable}, 1);
        repeat (TIMEOUT) @(negedge clk);
        chk("t4_terr_early", {31'd0, timeout_err}, 0);
        @(negedge clk);
        chk("t4_terr_set", {31'd0, timeout_err}, 1);
        chk("t4_idle", {31'd0, busy}, 0);
        repeat (12) @(negedge clk);
        chk("t4_late_mv", {31'd0, m_valid}, 0);
        chk("t4_late_busy", {31'd0, busy}, 0);
        model_delay = 5;
        m_ready = 1'b1;
        push(5'b10000, 4'b0111, 1'b1);
        s_valid = 1'b0;
        drain(60);
        chk("t4_terr_sticky", {31'd0, timeout_err}, 1);
        m_ready = 1'b0;

        // reset mid-op with three pairs queued
        model_delay = -1;
        for (int i = 0; i < 4; i++) begin
            ta = M'(i + 9);
            tb = N'(i + 1);
            push(ta, tb, 1'b0);
        end
        s_valid = 1'b0;
        chk("t6_cnt", {29'd0, fifo_count}, 3);
        chk("t6_busy", {31'd0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_cnt_rst", {29'd0, fifo_count}, 0);
        chk("t6_busy_rst", {31'd0, busy}, 0);
        chk("t6_mv_rst", {31'd0, m_valid}, 0);
        chk("t6_mdata_rst", {23'd0, m_data}, 0);
        chk("t6_ina_rst", {27'd0, mult_in_a}, 0);
        chk("t6_terr_rst", {31'd0, timeout_err}, 0);
        chk("t6_rdy_rst", {31'd0, s_ready}, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_delay = 5;
        e0 = en_count;
        repeat (40) @(negedge clk);
        chk("t6_no_issue", en_count - e0, 0);
        chk("t6_no_mv", {31'd0, m_valid}, 0);
        chk("t6_rdy", {31'd0, s_ready}, 1);

        // strobe on the final wait cycle beats the timeout
        model_delay = TIMEOUT;
        m_ready = 1'b1;
        push(5'b01111, 4'b1111, 1'b1);
        s_valid = 1'b0;
        drain(100);
        chk("t5_terr", {31'd0, timeout_err}, 0);
        m_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
- Operand scheduler that sits directly upstream of the serial shift-add multiplier `mult_basic` and also captures that multiplier's results.
- Buffers signed operand pairs from a valid/ready source in a small FIFO.
- Issues each pair as a single-cycle `mult_enable` pulse, and only when the multiplier is idle.
- Holds the single-cycle `mult_out_valid` result in a register and presents it to a valid/ready sink, so no result is lost under backpressure.

Parameters:
- M, 5, width of operand A (two's complement); must match the multiplier.
- N, 4, width of operand B (two's complement); must match the multiplier.
- DEPTH, 4, operand FIFO depth; power of 2, ≥ 2.
- TIMEOUT, 32, cycles to wait for `mult_out_valid` before abandoning an operation; must be > N+4.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  operand pair valid
- s_ready  out  1  FIFO can accept a pair
- s_a  in  M  operand A
- s_b  in  N  operand B
- mult_enable  out  1  start pulse to the multiplier
- mult_in_a  out  M  operand A to the multiplier
- mult_in_b  out  N  operand B to the multiplier
- mult_out  in  M+N  product from the multiplier
- mult_out_valid  in  1  product strobe from the multiplier (1 cycle)
- m_valid  out  1  result valid
- m_ready  in  1  sink accepts result
- m_data  out  M+N  signed product
- busy  out  1  any work pending
- timeout_err  out  1  sticky timeout flag
- fifo_count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync release): all outputs 0 except `s_ready`=1; FIFO empty; FSM in IDLE; `timeout_err`=0.
- Reset mid-operation discards FIFO contents, any in-flight result and the held result.
- FIFO:
  - Push on `s_valid && s_ready`.
  - `s_ready` = (`fifo_count` < DEPTH), registered from count; no pass-through when full.
  - A pop in the same cycle does not raise `s_ready` that cycle.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when `fifo_count` > 0 and `m_valid` = 0.
  - ISSUE:
    - lasts exactly 1 cycle;
    - `mult_enable`=1 with `mult_in_a`/`mult_in_b` = FIFO head;
    - head is popped on this edge;
    - next state is WAIT.
  - WAIT:
    - on `mult_out_valid`=1: capture `mult_out` into `m_data`, set `m_valid`=1, go to IDLE;
    - else if the wait counter reaches TIMEOUT-1: set `timeout_err`=1, go to IDLE, product discarded.
- Operand and enable outputs:
  - `mult_enable` is 0 in all states except ISSUE.
  - `mult_in_a`/`mult_in_b` hold their last issued values outside ISSUE.
- Latency:
  - A push accepted on edge E0 into an empty FIFO (IDLE, no held result) gives `mult_enable` high from E1 to E2.
  - The product appears on `m_data` one edge after `mult_out_valid`.
- Output handshake:
  - `m_valid` and `m_data` stay stable until `m_ready` = 1.
  - `m_valid` clears on the accepting edge.
  - A new issue requires `m_valid` = 0, so at most one operation is in flight.
- Ignored strobes:
  - `mult_out_valid` outside WAIT is ignored, including a late result after a timeout.
  - If `mult_out_valid` and timeout expiry occur in the same cycle, the valid wins and no error is flagged.
- `timeout_err` is sticky until reset.
- Wait counter: `clog2(TIMEOUT)` bits; cleared on entry to WAIT.
- `busy` = (state != IDLE) || (`fifo_count` != 0) || `m_valid`.
- Arithmetic: none internal; `m_data` is a bit-exact copy of `mult_out`.

Test Plan:
- Single op, M=5, N=4: push a=5'b11001 (-7), b=4'b0011 (3); bench multiplier model returns 9'h1EB (-21) -> one `mult_enable` pulse starting 1 cycle after push; `m_valid`=1 with `m_data`=9'h1EB one edge after strobe; `busy` falls after `m_ready`.
- Backpressure: push (5,-8) and (3,3) back-to-back, `m_ready`=0 for 20 cycles -> `m_data` held at 9'h1D8 (-40); no second `mult_enable` until accept; then 9'h009 delivered.
- FIFO full: with `m_ready`=0, push 6 pairs with `s_valid` held -> `s_ready`=0 once `fifo_count`=4; `fifo_count` never exceeds 4; after draining, all accepted pairs come out in push order with correct products.
- Timeout: model never returns a strobe -> `timeout_err`=1 exactly TIMEOUT cycles after entry to WAIT; FSM returns to IDLE; next pair is issued and completes normally; a late strobe is ignored.
- Same-cycle valid and timeout: strobe on the final wait cycle -> result captured, `timeout_err` stays 0.
- Reset mid-op: assert `rst_n`=0 during WAIT with 3 pairs queued -> all outputs 0 asynchronously, `s_ready`=1 after release, no stale result or issue afterwards.
